// File: rtl/contador_pkg.sv
// contador_pkg: default digit width, default per-stage moduli and modulus extraction shared by the counter cascade
package contador_pkg;
  localparam int DIGIT_W_DEF = 4;
  localparam logic [7:0] MODULI_DEF = {4'd10, 4'd12};
  // A slice value of 0 encodes 2^w, so a full-range modulus fits in a w-bit slice; w must stay below 31
  function automatic int mod_of(input logic [4095:0] m, input int w, input int i);
    int s;
    s = 0;
    for (int b = 0; b < w; b++) s[b] = m[i*w+b];
    return (s == 0) ? (1 << w) : s;
  endfunction
endpackage

// File: rtl/contador_digito.sv
// contador_digito: one modulo-MOD stage (clk, rst, step, up_dn, load, load_val in; q count, term terminal-value flag out)
module contador_digito #(
  parameter int DIGIT_W = 4,
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               term
);
  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);
  logic [DIGIT_W-1:0] q_q, q_d;
  assign q = q_q;
  assign term = up_dn ? (q_q == MAX) : (q_q == '0);
  always_comb begin
    q_d = load ? ((load_val > MAX) ? MAX : load_val)
        : !step ? q_q
        : up_dn ? (term ? '0 : q_q + 1'b1)
        : (term ? MAX : q_q - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
endmodule

// File: rtl/contador_cascata.sv
// contador_cascata: cascade of modulo digit stages (clk, rst, en, up_dn, load, load_val in; count, carry, wrap out)
module contador_cascata
  import contador_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter logic [NUM_STAGES*DIGIT_W-1:0] MODULI = MODULI_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [NUM_STAGES*DIGIT_W-1:0] load_val,
  output logic [NUM_STAGES*DIGIT_W-1:0] count,
  output logic [NUM_STAGES-1:0]         carry,
  output logic                          wrap
);
  logic [NUM_STAGES-1:0] term, step;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    localparam int M = mod_of(4096'(MODULI), DIGIT_W, g);
    if (M < 2 || M > 2**DIGIT_W) begin : g_bad
      $error("contador_cascata: illegal modulus %0d on stage %0d", M, g);
    end
    if (g == 0) begin : g_first
      assign step[g] = en & ~load;
    end else begin : g_next
      assign step[g] = carry[g-1];
    end
    contador_digito #(.DIGIT_W(DIGIT_W), .MOD(M)) u_dig (
      .clk      (clk),
      .rst      (rst),
      .step     (step[g]),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val[g*DIGIT_W +: DIGIT_W]),
      .q        (count[g*DIGIT_W +: DIGIT_W]),
      .term     (term[g])
    );
  end
  always_comb begin
    carry[0] = en & ~load & term[0];
    for (int i = 1; i < NUM_STAGES; i++) carry[i] = carry[i-1] & term[i];
  end
  assign wrap = carry[NUM_STAGES-1];
endmodule
